// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}; entry n is HEX_SEG[n].
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Convert an active-high segment pattern to the board's pin polarity.
  function automatic logic [6:0] seg_pol(input logic [6:0] v, input logic active_low);
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Nibble to active-high segment pattern; blank forces all segments off.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_hi
);

  assign seg_hi = blank ? 7'h00 : HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: prescaled digit slots with a blanking
// lead-in, per-digit enable mask, frame-aligned data snapshots, hex decode
// and leading-zero suppression. All outputs are registered.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - BLANK_CYCLES - 1);
  // With no blanking interval a slot starts directly in SHOW.
  localparam scan_state_t FIRST = (BLANK_CYCLES == 0) ? SHOW : BLANK;
  localparam logic AL = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] ONE = 1;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{AL}};

  scan_state_t state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [IDX_W-1:0] nxt_idx, lo_idx, up_idx;
  logic up_found, nxt_tick, take_snap;
  logic [4*NUM_DIGITS-1:0] snap_data, sd;
  logic [NUM_DIGITS-1:0] snap_dp, sdp;
  logic snap_lz, slz, zero_above, lz_blank;
  logic [6:0] dec_seg;

  // Lowest enabled digit, and lowest enabled digit above the current one.
  always_comb begin
    lo_idx   = '0;
    up_idx   = '0;
    up_found = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i]) lo_idx = IDX_W'(i);
      if (digit_mask[i] && (i > int'(digit_idx))) begin
        up_idx   = IDX_W'(i);
        up_found = 1'b1;
      end
    end
  end

  // Next-state decision; disable or empty mask always wins, even at a wrap.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_idx   = digit_idx;
    nxt_tick  = 1'b0;
    take_snap = 1'b0;
    if (!en || digit_mask == '0) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = FIRST;
          nxt_cnt   = '0;
          nxt_idx   = lo_idx;
          nxt_tick  = 1'b1;
          take_snap = 1'b1;
        end
        BLANK: if (cnt == BLK_LAST) begin
          nxt_state = SHOW;
          nxt_cnt   = '0;
        end
        SHOW: if (cnt == SHOW_LAST) begin
          nxt_state = FIRST;
          nxt_cnt   = '0;
          if (up_found) nxt_idx = up_idx;
          else begin
            nxt_idx   = lo_idx;
            nxt_tick  = 1'b1;
            take_snap = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Values the next cycle will display: fresh inputs on a frame start,
  // otherwise the held snapshot. Leading-zero blanking for the chosen digit.
  always_comb begin
    sd         = take_snap ? data : snap_data;
    sdp        = take_snap ? dp : snap_dp;
    slz        = take_snap ? lz_suppress : snap_lz;
    zero_above = 1'b1;
    lz_blank   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (sd[4*i +: 4] == 4'h0);
      if (i == int'(nxt_idx)) lz_blank = slz & zero_above;
    end
  end

  seg_hex_decoder u_dec (
    .nibble (sd[4*int'(nxt_idx) +: 4]),
    .blank  (lz_blank),
    .seg_hi (dec_seg)
  );

  // Scan FSM with registered outputs reflecting the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      snap_data  <= '0;
      snap_dp    <= '0;
      snap_lz    <= 1'b0;
      frame_tick <= 1'b0;
      anode      <= ANODE_OFF;
      seg        <= {7{AL}};
      dp_out     <= AL;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      digit_idx  <= nxt_idx;
      frame_tick <= nxt_tick;
      if (take_snap) begin
        snap_data <= data;
        snap_dp   <= dp;
        snap_lz   <= lz_suppress;
      end
      if (nxt_state == SHOW) begin
        anode  <= (ONE << nxt_idx) ^ ANODE_OFF;
        seg    <= seg_pol(dec_seg, AL);
        dp_out <= sdp[nxt_idx] ^ AL;
      end else begin
        anode  <= ANODE_OFF;
        seg    <= {7{AL}};
        dp_out <= AL;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles,
// active-low). Directed scenarios followed by randomized traffic, compared
// every cycle against a slot-position reference model.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  mask;
  logic [15:0] data;
  logic [3:0]  dpv;
  logic        lz;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_out;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int total = 0;
  int fails = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .digit_mask(mask), .data(data),
    .dp(dpv), .lz_suppress(lz), .anode(anode), .seg(seg), .dp_out(dp_out),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Active-high reference glyphs {g,f,e,d,c,b,a}.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: running flag, position within an 8-cycle slot, digit.
  int          m_run, m_pos, m_dig;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_lz, m_tick;

  function automatic int lowest_from(input int start, input logic [3:0] m);
    for (int i = start; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_dig = 0; m_tick = 1'b0;
    m_data = '0; m_dp = '0; m_lz = 1'b0;
  endtask

  task automatic take_snapshot();
    m_data = data; m_dp = dpv; m_lz = lz; m_tick = 1'b1;
  endtask

  task automatic model_step();
    int n;
    m_tick = 1'b0;
    if (reset) model_reset();
    else if (!en || mask == 4'h0) m_run = 0;
    else if (m_run == 0) begin
      m_run = 1; m_pos = 0; m_dig = lowest_from(0, mask);
      take_snapshot();
    end else begin
      m_pos++;
      if (m_pos == 8) begin
        m_pos = 0;
        n = lowest_from(m_dig + 1, mask);
        if (n < 0) begin
          m_dig = lowest_from(0, mask);
          take_snapshot();
        end else m_dig = n;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       blank;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_run != 0 && m_pos >= 2) begin
      e_an  = ~(4'b0001 << m_dig);
      blank = (m_dig > 0) && m_lz && ((m_data >> (4 * m_dig)) == 16'h0);
      e_seg = blank ? 7'h7F : ~glyph[(m_data >> (4 * m_dig)) & 16'hF];
      e_dp  = ~m_dp[m_dig];
    end
    chk("anode", anode, e_an);
    chk("seg", seg, e_seg);
    chk("dp_out", dp_out, e_dp);
    chk("digit_idx", digit_idx, m_dig[1:0]);
    chk("frame_tick", frame_tick, m_tick);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Reset raised between edges: outputs must go inactive without a clock.
  task automatic async_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_anode", anode, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp_out, 1'b1);
    chk("async_tick", frame_tick, 1'b0);
    chk("async_idx", digit_idx, 2'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mask = 4'h0; data = '0; dpv = '0; lz = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_anode", anode, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_tick", frame_tick, 1'b0);
    run(2);
    reset = 1'b0;
    run(3);

    // Full mask, 1234.
    en = 1'b1; mask = 4'hF; data = 16'h1234;
    run(70);
    // Sparse mask.
    mask = 4'b0101;
    run(40);
    // Leading-zero suppression.
    mask = 4'hF; lz = 1'b1; data = 16'h0007;
    run(40);
    data = 16'h0000;
    run(40);
    // Mid-frame data change with decimal points.
    lz = 1'b0; data = 16'hABCD; dpv = 4'b0101;
    run(12);
    data = 16'h5678; dpv = 4'b1010;
    run(40);
    // Reset mid-SHOW, en drop and raise.
    run(5);
    async_reset();
    run(20);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(20);
    // Single enabled digit.
    mask = 4'b0100;
    run(30);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      if ($urandom_range(0, 99) < 3) mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 5) data = 16'($urandom >> (4 * $urandom_range(3, 7)));
      if ($urandom_range(0, 99) < 5) dpv = 4'($urandom);
      if ($urandom_range(0, 99) < 2) lz = ~lz;
      if ($urandom_range(0, 999) < 3) async_reset();
      cyc();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
